// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// result_o = {remainder, quotient}; one quotient bit is produced per clock.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  // Counter value after the final iteration; in ON it marks the fix-up cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_W-1:0]     dvd_reg, dvd_next;   // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]     dsr_reg, dsr_next;   // divisor magnitude
  logic [DATA_W-1:0]     rem_reg, rem_next;   // partial remainder (always < divisor)
  logic                  neg_q_reg, neg_q_next;
  logic                  neg_r_reg, neg_r_next;
  logic [2*DATA_W-1:0]   result_reg, result_next;
  logic                  ready_reg, ready_next;

  logic [DATA_W:0]       shifted;
  logic [DATA_W:0]       trial;
  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W-1:0]     q_fix, r_fix;

  // Trial subtraction is DATA_W+1 bits wide; its MSB is the sign of the difference.
  assign shifted = {rem_reg, dvd_reg[DATA_W-1]};
  assign trial   = shifted - {1'b0, dsr_reg};

  // Operand magnitudes for signed mode; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Final sign correction, results taken mod 2^DATA_W.
  assign q_fix = neg_q_reg ? -dvd_reg : dvd_reg;
  assign r_fix = neg_r_reg ? -rem_reg : rem_reg;

  // State and datapath registers; async active-low reset aborts any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= FREE;
      cnt_reg    <= '0;
      dvd_reg    <= '0;
      dsr_reg    <= '0;
      rem_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dvd_reg    <= dvd_next;
      dsr_reg    <= dsr_next;
      rem_reg    <= rem_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  // Next-state, iteration step and registered-output values.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dvd_next    = dvd_reg;
    dsr_next    = dsr_reg;
    rem_next    = rem_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;
    ready_next  = ready_reg;

    if (annul_i) begin
      // A flush beats everything, including a same-cycle start.
      state_next  = FREE;
      cnt_next    = '0;
      result_next = '0;
      ready_next  = 1'b0;
    end else begin
      case (state_reg)
        FREE: begin
          ready_next  = 1'b0;
          result_next = '0;
          if (start_i) begin
            dvd_next   = op1_abs;
            dsr_next   = op2_abs;
            rem_next   = '0;
            cnt_next   = '0;
            neg_q_next = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_next = signed_div_i & opdata1_i[DATA_W-1];
            state_next = (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          // ready is raised one edge later by END itself.
          result_next = '0;
          ready_next  = 1'b0;
          state_next  = END;
        end
        ON: begin
          if (cnt_reg != LAST_CNT) begin
            if (!trial[DATA_W]) begin
              rem_next = trial[DATA_W-1:0];
              dvd_next = {dvd_reg[DATA_W-2:0], 1'b1};
            end else begin
              rem_next = shifted[DATA_W-1:0];
              dvd_next = {dvd_reg[DATA_W-2:0], 1'b0};
            end
            cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            result_next = {r_fix, q_fix};
            ready_next  = 1'b1;
            cnt_next    = '0;
            state_next  = END;
          end
        end
        END: begin
          if (start_i) begin
            ready_next = 1'b1;
          end else begin
            ready_next  = 1'b0;
            result_next = '0;
            state_next  = FREE;
          end
        end
        default: begin
          state_next  = FREE;
          cnt_next    = '0;
          result_next = '0;
          ready_next  = 1'b0;
        end
      endcase
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit with a queue of expected results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .annul_i(annul_i),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .result_o(result_o),
    .ready_o(ready_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Safety net in case a wait is ever left unbounded.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: divide magnitudes, then apply MIPS sign rules.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] aa, bb, q, r;
    if (b == 32'h0) return 64'h0;
    aa = (sgn && a[31]) ? -a : a;
    bb = (sgn && b[31]) ? -b : b;
    q = aa / bb;
    r = aa % bb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // One full transaction: request, wait for ready, compare, hold, release.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int exp_lat,
                         input int hold_extra, input bit wiggle, input bit pre_annul);
    int n;
    logic [63:0] want;
    sb.push_back(exp);
    @(negedge clk);
    start_i = 1'b1; annul_i = pre_annul; signed_div_i = sgn; opdata1_i = a; opdata2_i = b;
    @(posedge clk);
    n = 0;
    forever begin
      @(negedge clk);
      annul_i = 1'b0;
      if (ready_o === 1'b1 || n >= 100) break;
      if (wiggle) begin opdata1_i = $urandom; opdata2_i = $urandom; end
      @(posedge clk);
      n++;
    end
    check($sformatf("%s latency", tag), 64'(n), 64'(exp_lat));
    want = sb.pop_front();
    check($sformatf("%s result", tag), result_o, want);
    for (int i = 0; i < hold_extra; i++) begin
      if (wiggle) begin opdata1_i = $urandom; opdata2_i = $urandom; end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s hold%0d ready", tag, i), 64'(ready_o), 64'h1);
      check($sformatf("%s hold%0d result", tag, i), result_o, want);
    end
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s release ready", tag), 64'(ready_o), 64'h0);
    check($sformatf("%s release result", tag), result_o, 64'h0);
    $display("txn %s a=%h b=%h signed=%0d result=%h latency=%0d", tag, a, b, sgn, want, n);
  endtask

  initial begin
    bit seen_ready;
    int n;
    logic [31:0] ra, rb;
    logic rs;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(ready_o), 64'h0);
    check("reset result", result_o, 64'h0);
    rst = 1'b1;

    // Main function
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0, 1'b0, 1'b0);
    run_div("div_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b0, 1'b0);
    run_div("div_7_m2", 32'h7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 0, 1'b0, 1'b0);
    run_div("div_by_zero", 32'h12345678, 32'h0, 1'b0, 64'h0, 2, 1, 1'b0, 1'b0);
    run_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 0, 1'b0, 1'b0);

    // Annul at N+10 with the request withdrawn: nothing may be delivered.
    @(negedge clk);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    check("annul result", result_o, 64'h0);
    seen_ready = 1'b0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o !== 1'b0) seen_ready = 1'b1;
    end
    check("annul no ready", 64'(seen_ready), 64'h0);
    $display("txn annul a=%h b=%h ready_seen=%0d", 32'd1000, 32'd3, seen_ready);
    run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 0, 1'b0, 1'b0);

    // Annul beats start in the same cycle: acceptance slips by one edge.
    run_div("annul_prio", 32'd20, 32'd6, 1'b0, 64'h00000002_00000003, 34, 0, 1'b0, 1'b1);

    // Asynchronous reset mid-operation at N+15, off the clock edge.
    @(negedge clk);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd7;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async rst ready", 64'(ready_o), 64'h0);
    check("async rst result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("txn reset_mid a=%h b=%h aborted", 32'hDEADBEEF, 32'd7);
    run_div("post_rst_divu", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 0, 1'b0, 1'b0);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("end hold result", result_o, 64'h00000000_0000000A);
    #2 rst = 1'b0;
    #1;
    check("end rst ready", 64'(ready_o), 64'h0);
    check("end rst result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("txn reset_end a=%h b=%h cleared", 32'd50, 32'd5);

    // Operand stability: inputs scrambled every cycle, result held 5 extra cycles.
    run_div("stable", 32'h87654321, 32'h00001234, 1'b0,
            model(32'h87654321, 32'h00001234, 1'b0), 33, 5, 1'b1, 1'b0);

    // A few random operands against the reference.
    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = (k == 3) ? 32'h0 : $urandom;
      rs = k[0];
      run_div($sformatf("rand%0d", k), ra, rb, rs, model(ra, rb, rs),
              (rb == 32'h0) ? 2 : 33, 0, 1'b0, 1'b0);
    end

    check("scoreboard empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU.
- Acts as the responder to the execute stage, which is the initiator: EX raises start_i with the operands and stalls until ready_o.
- EX then forwards result_o to the HI/LO write path: HI = remainder, LO = quotient.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- DATA_W, 32, operand width. Quotient and remainder are each DATA_W bits; result_o is 2*DATA_W.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start_i  in  1  divide request, held high by EX until ready_o is seen
- annul_i  in  1  cancel: pipeline flush/exception
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- result_o  out  2*DATA_W  {remainder, quotient}
- ready_o  out  1  result valid

Behaviour:
- Reset (rst=0, async): state=FREE, ready_o=0, result_o=0, counter=0, internal dividend/divisor regs=0.
- States: FREE, BYZERO, ON, END. All outputs are registered.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON.
  - On either transition, latch operands and sign mode. Any later change on the operand inputs is ignored.
  - Signed mode latches absolute values plus two flags: neg_q = sign(op1) XOR sign(op2), and neg_r = sign(op1).
  - Otherwise stay in FREE with ready_o=0.
- BYZERO: next edge -> END with result_o=0.
- ON, counter 0..31: each edge performs one shift/trial-subtract step.
  - Partial remainder is DATA_W+1 bits; a non-negative trial difference shifts in quotient bit 1.
  - The edge that completes step 31 enters a fix-up cycle (counter=32).
  - The next edge applies the sign correction, writes result_o and ready_o=1, and moves to END.
  - Signed correction: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r. Results are mod 2^DATA_W.
  - 0x80000000 / 0xFFFFFFFF therefore gives q=0x80000000, r=0 (no trap).
- Latency:
  - start sampled at edge N (non-zero divisor): iterations occur at edges N+1..N+32, and result_o/ready_o are valid after edge N+33.
  - Zero divisor: ready_o=1 after edge N+2.
- END: hold ready_o=1 and result_o stable while start_i=1. On the first edge with start_i=0 -> FREE, ready_o=0, result_o=0.
- annul_i=1 in any state forces FREE on the next edge, with ready_o=0, result_o=0 and counter=0. No result is ever delivered for an annulled request.
- annul_i has priority over start_i in the same cycle.
- Reset asserted mid-operation aborts immediately to the reset values. After reset is released, a fresh start is required.
- Back-to-back divides: once in FREE, a new start_i is accepted on the next edge. A minimum of 1 idle cycle between requests is inherent.

Test Plan:
- DIVU: 100 / 7, start held -> ready_o rises after edge N+33; result_o=64'h00000002_0000000E. Drop start -> FREE, ready_o=0 next edge.
- DIV: -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD. Also 7 / -2 -> 64'h00000001_FFFFFFFD.
- Zero divisor: 0x12345678 / 0 -> ready_o after edge N+2; result_o=0. Operand corner 0x80000000 / 0xFFFFFFFF signed -> 64'h00000000_80000000.
- Annul: assert annul_i for one cycle at N+10 -> ready_o stays 0 through N+40; state FREE. A following 9/3 completes with 64'h00000000_00000003.
- Async reset: drive rst=0 mid-way at N+15, not clock-aligned -> ready_o/result_o go to 0 immediately. After release, 0xFFFFFFFF / 1 DIVU -> 64'h00000000_FFFFFFFF.
- Operand stability: change opdata1_i/opdata2_i every cycle after start; hold start 5 extra cycles in END -> result matches the latched operands and stays constant until start_i drops.
